// File: rtl/typing_round_controller.sv
// Typing-game round sequencer between the PS/2 decoder and Keyboard_Parser.
// Optional round timer enabled by defining ROUND_TIMER_EN.
module typing_round_controller #(
  parameter int NUM_LEVELS       = 4,
  parameter int LOAD_WAIT_CYCLES = 3,
  parameter int TICKS_PER_SEC    = 50_000_000,
  parameter int ROUND_SECONDS    = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic [7:0] comparison_data,
  input  logic [7:0] num_char,
  output logic       enable_next_level,
  output logic       get_next_character,
  output logic [3:0] level,
  output logic [7:0] chars_typed,
  output logic [7:0] error_count,
  output logic [7:0] seconds_left,
  output logic       round_active,
  output logic       round_done,
  output logic       game_over,
  output logic       timed_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LOAD_WAIT, S_PLAY, S_ADVANCE, S_ROUND_DONE, S_GAME_OVER
  } state_t;

  localparam int WAIT_W = (LOAD_WAIT_CYCLES > 1) ? $clog2(LOAD_WAIT_CYCLES) : 1;

  state_t             state_q;
  logic [3:0]         level_q;
  logic [7:0]         chars_typed_q;
  logic [7:0]         error_count_q;
  logic [7:0]         error_count_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [7:0]         word_len;
  logic               key_hit;
  logic               new_game;
  logic               timeout;

  // An empty word still needs one correct key to finish the round.
  assign word_len      = (num_char == 8'd0) ? 8'd1 : num_char;
  assign error_count_d = (error_count_q == 8'hFF) ? error_count_q : error_count_q + 8'd1;
  assign key_hit       = key_valid && (key_code == comparison_data);
  assign new_game      = start && ((state_q == S_IDLE) || (state_q == S_GAME_OVER));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      level_q       <= '0;
      chars_typed_q <= '0;
      error_count_q <= '0;
      wait_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (new_game) begin
            level_q       <= '0;
            error_count_q <= '0;
            chars_typed_q <= '0;
            state_q       <= S_ARM;
          end
        end
        S_ARM: begin
          wait_q  <= '0;
          state_q <= (LOAD_WAIT_CYCLES == 0) ? S_PLAY : S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          if (wait_q == WAIT_W'(LOAD_WAIT_CYCLES - 1)) state_q <= S_PLAY;
          else wait_q <= wait_q + WAIT_W'(1);
        end
        S_PLAY: begin
          if (timeout) begin
            state_q <= S_GAME_OVER;
          end else if (key_hit) begin
            chars_typed_q <= chars_typed_q + 8'd1;
            state_q       <= S_ADVANCE;
          end else if (key_valid) begin
            error_count_q <= error_count_d;
          end
        end
        S_ADVANCE: begin
          state_q <= (chars_typed_q == word_len) ? S_ROUND_DONE : S_PLAY;
        end
        S_ROUND_DONE: begin
          if (start) begin
            if (level_q == 4'(NUM_LEVELS - 1)) begin
              state_q <= S_GAME_OVER;
            end else begin
              level_q       <= level_q + 4'd1;
              chars_typed_q <= '0;
              state_q       <= S_ARM;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ROUND_TIMER_EN
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [TICK_W-1:0] tick_q;
  logic [7:0]        seconds_left_q;
  logic              timed_out_q;
  logic              in_round;
  logic              go_arm;
  logic              sec_wrap;

  assign in_round = (state_q == S_PLAY) || (state_q == S_ADVANCE);
  assign go_arm   = new_game ||
                    (start && (state_q == S_ROUND_DONE) && (level_q != 4'(NUM_LEVELS - 1)));
  assign sec_wrap = in_round && (tick_q == TICK_W'(TICKS_PER_SEC - 1));
  assign timeout  = (state_q == S_PLAY) && (seconds_left_q == 8'd0);

  // Time only runs while the player can type; the load and done phases are free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_q         <= '0;
      seconds_left_q <= '0;
      timed_out_q    <= 1'b0;
    end else begin
      if (go_arm) begin
        tick_q         <= '0;
        seconds_left_q <= 8'(ROUND_SECONDS);
      end else if (in_round) begin
        tick_q <= sec_wrap ? '0 : tick_q + TICK_W'(1);
        if (sec_wrap && (seconds_left_q != 8'd0)) seconds_left_q <= seconds_left_q - 8'd1;
      end
      if (new_game) timed_out_q <= 1'b0;
      else if (timeout) timed_out_q <= 1'b1;
    end
  end

  assign seconds_left = seconds_left_q;
  assign timed_out    = timed_out_q;
`else
  assign timeout      = 1'b0;
  assign seconds_left = 8'd0;
  assign timed_out    = 1'b0;
`endif

  assign enable_next_level  = (state_q == S_ARM);
  assign get_next_character = (state_q == S_ADVANCE);
  assign round_active       = (state_q == S_PLAY) || (state_q == S_ADVANCE);
  assign round_done         = (state_q == S_ROUND_DONE);
  assign game_over          = (state_q == S_GAME_OVER);
  assign level              = level_q;
  assign chars_typed        = chars_typed_q;
  assign error_count        = error_count_q;

endmodule

// File: tb/tb_typing_round_controller.sv
// Self-checking bench for typing_round_controller with a behavioural parser partner
// and a game-level reference model compared on every cycle.
module tb_typing_round_controller;
  localparam int NL  = 4;
  localparam int LW  = 3;
  localparam int TPS = 10;
  localparam int RS  = 5;
`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, start, key_valid;
  logic [7:0] key_code, comparison_data, num_char;
  logic       enable_next_level, get_next_character;
  logic [3:0] level;
  logic [7:0] chars_typed, error_count, seconds_left;
  logic       round_active, round_done, game_over, timed_out;

  typing_round_controller #(
    .NUM_LEVELS(NL), .LOAD_WAIT_CYCLES(LW), .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid), .key_code(key_code),
    .comparison_data(comparison_data), .num_char(num_char),
    .enable_next_level(enable_next_level), .get_next_character(get_next_character),
    .level(level), .chars_typed(chars_typed), .error_count(error_count),
    .seconds_left(seconds_left), .round_active(round_active), .round_done(round_done),
    .game_over(game_over), .timed_out(timed_out)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;
  int gnc_cnt = 0;
  int enl_cnt = 0;

  // Parser partner: word table, load pointer and character index.
  logic [7:0] words [4][5];
  int lens [4] = '{5, 3, 4, 0};
  int p_word, p_next, p_idx;

  // Game-level model: load countdown, typing flag, pending shift, round/game end flags.
  int m_count, m_level, m_chars, m_errs, m_ticks;
  bit m_typing, m_shift, m_done, m_over, m_armed, m_to;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_secs();
    int s;
    if (!TIMER || !m_armed) return 32'd0;
    s = RS - m_ticks / TPS;
    return (s < 0) ? 32'd0 : 32'(s);
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      chk("enable_next_level", {31'd0, enable_next_level}, {31'd0, m_count == LW + 1});
      chk("get_next_character", {31'd0, get_next_character}, {31'd0, m_shift});
      chk("round_active", {31'd0, round_active}, {31'd0, m_typing});
      chk("round_done", {31'd0, round_done}, {31'd0, m_done});
      chk("game_over", {31'd0, game_over}, {31'd0, m_over});
      chk("timed_out", {31'd0, timed_out}, {31'd0, m_to});
      chk("level", {28'd0, level}, 32'(m_level));
      chk("chars_typed", {24'd0, chars_typed}, 32'(m_chars));
      chk("error_count", {24'd0, error_count}, 32'(m_errs));
      chk("seconds_left", {24'd0, seconds_left}, exp_secs());
      if (get_next_character === 1'b1) gnc_cnt++;
      if (enable_next_level === 1'b1) enl_cnt++;
    end
  end

  task automatic model_step();
    int secs_now, len;
    if (!resetn) begin
      m_count = 0; m_level = 0; m_chars = 0; m_errs = 0; m_ticks = 0;
      m_typing = 0; m_shift = 0; m_done = 0; m_over = 0; m_armed = 0; m_to = 0;
      p_word = 0; p_next = 0; p_idx = 0;
      return;
    end
    if (m_count == LW + 1) begin
      p_word = p_next; p_next = (p_next + 1) % NL; p_idx = 0;
    end
    if (m_shift) p_idx++;
    secs_now = int'(exp_secs());
    len = (num_char == 8'd0) ? 1 : int'(num_char);
    if (m_count > 0) begin
      m_count--;
      if (m_count == 0) m_typing = 1;
    end else if (m_typing && m_shift) begin
      m_ticks++;
      m_shift = 0;
      if (m_chars == len) begin m_typing = 0; m_done = 1; end
    end else if (m_typing) begin
      m_ticks++;
      if (TIMER && secs_now == 0) begin
        m_typing = 0; m_over = 1; m_to = 1;
      end else if (key_valid) begin
        if (key_code == comparison_data) begin m_shift = 1; m_chars++; end
        else if (m_errs < 255) m_errs++;
      end
    end else if (start) begin
      if (m_done && m_level == NL - 1) begin
        m_done = 0; m_over = 1;
      end else begin
        if (m_done) m_level++;
        else begin m_level = 0; m_errs = 0; m_to = 0; end
        m_done = 0; m_over = 0; m_chars = 0; m_ticks = 0; m_armed = 1;
        m_count = LW + 1;
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit s, input bit kv, input logic [7:0] kc);
    resetn = rn; start = s; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step();
    #1;
    comparison_data = words[p_word][p_idx % 5];
    num_char = 8'(lens[p_word]);
  endtask

  task automatic nop();
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic key(input logic [7:0] k);
    cyc(1'b1, 1'b0, 1'b1, k);
  endtask

  task automatic wait_play(output int n);
    n = 0;
    while (round_active !== 1'b1 && n < 20) begin nop(); n++; end
    chk("wait_play", {31'd0, round_active}, 32'd1);
  endtask

  task automatic type_word();
    int n = 0;
    while (round_done !== 1'b1 && n < 40) begin key(comparison_data); nop(); n++; end
    chk("word_finished", {31'd0, round_done}, 32'd1);
  endtask

  initial begin
    int n, g0;
    words[0] = '{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44};
    words[1] = '{8'h2C, 8'h1C, 8'h1B, 8'h00, 8'h00};
    words[2] = '{8'h4D, 8'h44, 8'h3C, 8'h2D, 8'h00};
    words[3] = '{8'h2B, 8'h00, 8'h00, 8'h00, 8'h00};
    resetn = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    comparison_data = 8'h33; num_char = 8'd5;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    checking = 1'b1;
    chk("lit_reset_level", {28'd0, level}, 32'd0);
    chk("lit_reset_active", {31'd0, round_active}, 32'd0);
    chk("lit_reset_errors", {24'd0, error_count}, 32'd0);

    // First round: load latency, one wrong key, a key dropped during the shift cycle.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    wait_play(n);
    chk("lit_play_latency", 32'(n), 32'(LW + 1));
    chk("lit_enable_pulses", 32'(enl_cnt), 32'd1);
    key(8'h1C);
    key(8'h33);
    cyc(1'b1, 1'b0, 1'b1, 8'h55);
    chk("lit_errors_after_1C", {24'd0, error_count}, 32'd1);
    chk("lit_chars_after_33", {24'd0, chars_typed}, 32'd1);
    key(8'h24); nop(); key(8'h4B); nop(); key(8'h4B); nop(); key(8'h44); nop();
    chk("lit_word0_chars", {24'd0, chars_typed}, 32'd5);
    chk("lit_word0_done", {31'd0, round_done}, 32'd1);
    chk("lit_word0_pulses", 32'(gnc_cnt), 32'd5);

    // Remaining levels, including the zero-length word, then game over.
    for (int lv = 1; lv < NL; lv++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      wait_play(n);
      chk("lit_level", {28'd0, level}, 32'(lv));
      type_word();
    end
    chk("lit_last_word_chars", {24'd0, chars_typed}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    chk("lit_game_over", {31'd0, game_over}, 32'd1);

    // Restart from game over, then reset while shifting.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    wait_play(n);
    chk("lit_restart_level", {28'd0, level}, 32'd0);
    key(comparison_data);
    g0 = gnc_cnt;
    cyc(1'b0, 1'b0, 1'b1, comparison_data);
    chk("lit_rst_active", {31'd0, round_active}, 32'd0);
    chk("lit_rst_chars", {24'd0, chars_typed}, 32'd0);
    nop(); nop();
    chk("lit_rst_pulses", 32'(gnc_cnt), 32'(g0 + 1));

    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    wait_play(n);
    if (TIMER) begin
      repeat (60) nop();
      chk("lit_timeout_over", {31'd0, game_over}, 32'd1);
      chk("lit_timeout_flag", {31'd0, timed_out}, 32'd1);
    end else begin
      repeat (260) key(comparison_data ^ 8'hFF);
      chk("lit_error_saturate", {24'd0, error_count}, 32'd255);
    end

    for (int i = 0; i < 3000; i++) begin
      bit rn, s, kv;
      logic [7:0] kc;
      rn = ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 15) == 0);
      kv = ($urandom_range(0, 2) == 0);
      kc = ($urandom_range(0, 3) != 0) ? comparison_data : 8'($urandom_range(0, 255));
      cyc(rn, s, kv, kc);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
